// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared widths, stall-vector bit positions, load-op encodings, capture
//   FSM states and the packed layouts of the EX->MEM and MEM->WB buses.
//   Imported by mem_stage and load_align.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 79;
    localparam int MEM_TO_WB_WD = 70;
    localparam int STALL_W      = 6;

    // Stall vector bit positions and polarity.
    localparam int   STALL_MEM = 3;
    localparam int   STALL_WB  = 4;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    typedef enum logic [2:0] {
        LOAD_LW  = 3'b000,
        LOAD_LB  = 3'b001,
        LOAD_LBU = 3'b010,
        LOAD_LH  = 3'b011,
        LOAD_LHU = 3'b100
    } load_op_e;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_HOLD = 1'b1
    } cap_state_e;

    // EX->MEM bus, MSB first.
    typedef struct packed {
        logic [2:0]  load_op;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
    } ex_to_mem_t;

    // MEM->WB bus, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    // A load is an enabled data-RAM access with no byte writes.
    function automatic logic is_load(input ex_to_mem_t b);
        return b.ram_en && (b.ram_wen == 4'b0000);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align
//   Combinational byte/halfword extraction of a 32-bit little-endian word
//   with sign or zero extension.
// Ports:
//   raw_i      32-bit word read from the data SRAM (or capture buffer)
//   addr_i     low two address bits selecting the byte/halfword
//   load_op_i  load type; unknown encodings behave as a word load
//   value_o    extended 32-bit result
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  load_op_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned addresses are not trapped: the low bits select directly.
    assign byte_sel = raw_i[{addr_i, 3'b000} +: 8];
    assign half_sel = addr_i[1] ? raw_i[31:16] : raw_i[15:0];

    always_comb begin
        value_o = raw_i;
        case (load_op_i)
            LOAD_LB:  value_o = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: value_o = {24'h0, byte_sel};
            LOAD_LH:  value_o = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: value_o = {16'h0, half_sel};
            default:  value_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access pipeline stage. Registers the EX->MEM bus under stall
//   control, selects and aligns SRAM load data, and produces the MEM->WB bus
//   plus the MEM-stage forwarding signals. A capture buffer keeps the
//   single-cycle SRAM read data alive while writeback is stalled.
// Ports:
//   clk              clock
//   rst              asynchronous active-low reset
//   stall            global stall vector (bit 3 MEM, bit 4 WB, 1 = stop)
//   ex_to_mem_bus    incoming EX->MEM bus
//   data_sram_rdata  SRAM read data, valid in a load's first MEM cycle
//   mem_to_wb_bus    outgoing MEM->WB bus {pc, rf_we, rf_waddr, rf_wdata}
//   MEM_ID           forwarding data (= rf_wdata)
//   MEM_wb_en        forwarding write enable
//   MEM_wb_r         forwarding destination register
module mem_stage #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [31:0]             MEM_ID,
    output logic                    MEM_wb_en,
    output logic [4:0]              MEM_wb_r
);
    import mem_stage_pkg::*;

    ex_to_mem_t bus_q, bus_d;
    cap_state_e state_q, state_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        entered_q, entered_d;

    logic        mem_stop, wb_stop, reg_update;
    logic [31:0] raw, load_value, rf_wdata;
    mem_to_wb_t  wb_s;
    logic        stall_unused;

    assign mem_stop   = (stall[STALL_MEM] == STOP);
    assign wb_stop    = (stall[STALL_WB] == STOP);
    // The register changes (bubble or new instruction) unless both stop.
    assign reg_update = !mem_stop || !wb_stop;

    assign stall_unused = ^{stall[STALL_MEM-1:0], stall[STALL_W-1:STALL_WB+1]};

    // Stage register: bubble has priority over load, otherwise hold.
    always_comb begin
        bus_d     = bus_q;
        entered_d = 1'b0;
        if (mem_stop && !wb_stop) begin
            bus_d = '0;
        end else if (!mem_stop) begin
            bus_d     = ex_to_mem_bus;
            entered_d = 1'b1;
        end
    end

    // Capture FSM. The SRAM data is only valid in the first cycle a load
    // sits in MEM, so it is latched exactly then if writeback is stalled.
    // The !reg_update term only matters for non-monotonic stall vectors,
    // where the load leaves MEM anyway and nothing needs capturing.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        raw         = data_sram_rdata;
        case (state_q)
            CAP_IDLE: begin
                if (entered_q && is_load(bus_q) && wb_stop && !reg_update) begin
                    state_d     = CAP_HOLD;
                    hold_data_d = data_sram_rdata;
                end
            end
            CAP_HOLD: begin
                raw = hold_data_q;
                if (reg_update) begin
                    state_d = CAP_IDLE;
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_q       <= '0;
            state_q     <= CAP_IDLE;
            hold_data_q <= '0;
            entered_q   <= 1'b0;
        end else begin
            bus_q       <= bus_d;
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            entered_q   <= entered_d;
        end
    end

    load_align u_load_align (
        .raw_i     (raw),
        .addr_i    (bus_q.result[1:0]),
        .load_op_i (bus_q.load_op),
        .value_o   (load_value)
    );

    assign rf_wdata = bus_q.sel_rf_res ? load_value : bus_q.result;

    assign wb_s.pc       = bus_q.pc;
    assign wb_s.rf_we    = bus_q.rf_we;
    assign wb_s.rf_waddr = bus_q.rf_waddr;
    assign wb_s.rf_wdata = rf_wdata;

    assign mem_to_wb_bus = wb_s;
    assign MEM_ID        = rf_wdata;
    assign MEM_wb_en     = bus_q.rf_we;
    assign MEM_wb_r      = bus_q.rf_waddr;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Directed bench for mem_stage. A behavioural model tracks which
//   instruction occupies MEM and the SRAM word seen in its first MEM cycle;
//   a negedge process compares every output against it each cycle, and
//   literal checks pin the model at hand-computed points.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic [78:0] ex_bus = '0;
    logic [31:0] rdata = '0;
    wire  [69:0] wb_bus;
    wire  [31:0] mem_id;
    wire         wb_en;
    wire  [4:0]  wb_r;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0]  S_NONE = 6'b000000;
    localparam logic [5:0]  S_BOTH = 6'b011000;
    localparam logic [5:0]  S_MEM  = 6'b001000;
    localparam logic [78:0] NOP    = '0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb_bus),
        .MEM_ID          (mem_id),
        .MEM_wb_en       (wb_en),
        .MEM_wb_r        (wb_r)
    );

    function automatic logic [78:0] mk(input logic [2:0] op, input logic [31:0] pc,
                                       input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {op, pc, en, wen, sel, we, wa, res};
    endfunction

    // Little-endian extraction by shifting and masking.
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] w,
                                               input logic [1:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'h0000_00FF;
        h = (w >> (16 * a[1])) & 32'h0000_FFFF;
        case (op)
            3'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    // Model: the instruction in MEM, whether it arrived this cycle, and the
    // SRAM word present during its first cycle there.
    logic [78:0] m_bus = '0;
    logic        m_fresh = 1'b0;
    logic [31:0] m_first = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_bus   <= '0;
            m_fresh <= 1'b0;
        end else if (!stall[3]) begin
            m_bus   <= ex_bus;
            m_fresh <= 1'b1;
        end else begin
            m_fresh <= 1'b0;
            if (!stall[4]) m_bus <= '0;
        end
    end

    always @(negedge clk) begin : cmp
        logic [31:0] wd;
        logic [69:0] exp_bus;
        if (rst && m_fresh) m_first = rdata;
        wd = m_bus[38] ? model_load(m_bus[78:76], m_first, m_bus[1:0]) : m_bus[31:0];
        exp_bus = {m_bus[75:44], m_bus[37], m_bus[36:32], wd};
        checks++;
        if ({wb_bus, mem_id, wb_en, wb_r} !== {exp_bus, wd, m_bus[37], m_bus[36:32]}) begin
            errors++;
            $display("FAIL cycle_compare t=%0t: got bus=%h id=%h en=%b r=%0d, want bus=%h id=%h en=%b r=%0d",
                     $time, wb_bus, mem_id, wb_en, wb_r, exp_bus, wd, m_bus[37], m_bus[36:32]);
        end
    end

    // Waits for the active edge, then presents the next cycle's inputs.
    task automatic cyc(input logic [78:0] b, input logic [31:0] rd, input logic [5:0] st);
        @(posedge clk);
        #2;
        ex_bus = b;
        rdata  = rd;
        stall  = st;
        #1;
    endtask

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        cyc(NOP, 32'h0, S_NONE);
        cyc(NOP, 32'h0, S_NONE);
        chk("reset_bus", wb_bus, 70'h0);
        chk("reset_id", mem_id, 70'h0);
        @(posedge clk);
        #2 rst = 1'b1;

        // ALU result forwarding.
        cyc(mk(3'd0, 32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF), 32'h0, S_NONE);
        cyc(NOP, 32'h0, S_NONE);
        chk("alu_id", mem_id, 70'hDEAD_BEEF);
        chk("alu_r", wb_r, 70'd9);
        chk("alu_en", wb_en, 70'd1);
        chk("alu_pc", wb_bus[69:38], 70'h100);

        // Byte / halfword extraction, pipelined back to back.
        cyc(mk(3'd1, 32'h200, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h1003), 32'h0, S_NONE);
        cyc(mk(3'd2, 32'h204, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h1003), 32'h80FF_7F01, S_NONE);
        chk("lb_sign", mem_id, 70'hFFFF_FF80);
        cyc(mk(3'd3, 32'h208, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h1000), 32'h80FF_7F01, S_NONE);
        chk("lbu_zero", mem_id, 70'h0000_0080);
        cyc(mk(3'd4, 32'h20C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h1002), 32'h80FF_7F01, S_NONE);
        chk("lh_low", mem_id, 70'h0000_7F01);
        cyc(NOP, 32'h80FF_7F01, S_NONE);
        chk("lhu_high", mem_id, 70'h0000_80FF);

        // Load held by writeback stall while SRAM data turns to junk.
        cyc(mk(3'd0, 32'h300, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h1000), 32'h0, S_NONE);
        cyc(NOP, 32'h1234_5678, S_BOTH);
        chk("hold_c0", mem_id, 70'h1234_5678);
        cyc(NOP, 32'hBAD0_0001, S_BOTH);
        chk("hold_c1", mem_id, 70'h1234_5678);
        cyc(NOP, 32'hBAD0_0002, S_BOTH);
        chk("hold_c2", mem_id, 70'h1234_5678);
        cyc(NOP, 32'hBAD0_0003, S_NONE);
        chk("hold_c3", mem_id, 70'h1234_5678);
        cyc(NOP, 32'hBAD0_0004, S_NONE);
        chk("hold_clear", mem_id, 70'h0);

        // Bubble: MEM stops, WB runs; the waiting EX op is not taken.
        cyc(mk(3'd0, 32'h400, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h55), 32'h0, S_NONE);
        cyc(mk(3'd0, 32'h404, 1'b0, 4'h0, 1'b0, 1'b1, 5'd12, 32'h66), 32'h0, S_MEM);
        chk("pre_bubble_en", wb_en, 70'd1);
        cyc(NOP, 32'h0, S_NONE);
        chk("bubble_bus", wb_bus, 70'h0);
        chk("bubble_en", wb_en, 70'd0);

        // Store under writeback stall.
        cyc(mk(3'd0, 32'h500, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h2000), 32'h0, S_NONE);
        cyc(NOP, 32'h0000_AAAA, S_BOTH);
        chk("store_en0", wb_en, 70'd0);
        cyc(NOP, 32'h0000_BBBB, S_BOTH);
        chk("store_en1", wb_en, 70'd0);
        cyc(NOP, 32'h0000_CCCC, S_NONE);
        chk("store_id", mem_id, 70'h2000);
        cyc(NOP, 32'h0, S_NONE);

        // Reset while a load is captured.
        cyc(mk(3'd0, 32'h600, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h40), 32'h0, S_NONE);
        cyc(NOP, 32'hCAFE_F00D, S_BOTH);
        chk("pre_rst_id", mem_id, 70'hCAFE_F00D);
        cyc(NOP, 32'h0000_0001, S_BOTH);
        chk("pre_rst_hold", mem_id, 70'hCAFE_F00D);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        rdata = 32'h0;
        stall = S_NONE;
        #1;
        chk("rst_bus", wb_bus, 70'h0);
        chk("rst_id", mem_id, 70'h0);
        chk("rst_en", wb_en, 70'd0);
        cyc(NOP, 32'h0, S_NONE);
        @(posedge clk);
        #2 rst = 1'b1;

        // First load after reset uses fresh SRAM data, not the old capture.
        cyc(mk(3'd0, 32'h700, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h80), 32'h0, S_NONE);
        cyc(NOP, 32'h1111_2222, S_NONE);
        chk("post_rst_id", mem_id, 70'h1111_2222);
        chk("post_rst_known", {69'h0, $isunknown({wb_bus, mem_id, wb_en, wb_r})}, 70'h0);
        cyc(NOP, 32'h0, S_NONE);
        cyc(NOP, 32'h0, S_NONE);

        @(posedge clk);
        #6;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
